// File: rtl/cache_line_loader_if.sv
// Miss-handler bus: CPU-side miss request, cache fill port and burst RAM command/data channels.
// With CACHE_LINE_LOADER_CRITICAL_WORD_FIRST_EN the bus also carries hit_word_valid.
interface cache_line_loader_if #(
    parameter int COLUMN_IX_BITWIDTH = 2,
    parameter int ADDRESS_BITWIDTH   = 32
);
    localparam int LINE_BITS = 32 << COLUMN_IX_BITWIDTH;

    logic                        miss_req;
    logic [ADDRESS_BITWIDTH-1:0] miss_addr;
    logic                        evict_dirty;
    logic [ADDRESS_BITWIDTH-1:0] evict_addr;
    logic [LINE_BITS-1:0]        evict_data;
    logic                        busy;
    logic                        done;
    logic                        cache_we;
    logic [ADDRESS_BITWIDTH-1:0] cache_addr;
    logic [31:0]                 cache_data;
    logic                        br_cmd_valid;
    logic                        br_cmd_write;
    logic [ADDRESS_BITWIDTH-1:0] br_cmd_addr;
    logic                        br_cmd_ready;
    logic [31:0]                 br_wdata;
    logic                        br_wdata_ack;
    logic [31:0]                 br_rdata;
    logic                        br_rdata_valid;
`ifdef CACHE_LINE_LOADER_CRITICAL_WORD_FIRST_EN
    logic                        hit_word_valid;
`endif

    modport slave (
`ifdef CACHE_LINE_LOADER_CRITICAL_WORD_FIRST_EN
        output hit_word_valid,
`endif
        input  miss_req, miss_addr, evict_dirty, evict_addr, evict_data,
        input  br_cmd_ready, br_wdata_ack, br_rdata, br_rdata_valid,
        output busy, done, cache_we, cache_addr, cache_data,
        output br_cmd_valid, br_cmd_write, br_cmd_addr, br_wdata
    );

    modport master (
`ifdef CACHE_LINE_LOADER_CRITICAL_WORD_FIRST_EN
        input  hit_word_valid,
`endif
        output miss_req, miss_addr, evict_dirty, evict_addr, evict_data,
        output br_cmd_ready, br_wdata_ack, br_rdata, br_rdata_valid,
        input  busy, done, cache_we, cache_addr, cache_data,
        input  br_cmd_valid, br_cmd_write, br_cmd_addr, br_wdata
    );
endinterface

// File: rtl/cache_line_loader.sv
// Cache miss handler: writes back a dirty victim line, then fills the missed 4-word line into the cache.
// Latency: miss_req->br_cmd_valid 1 cycle, rdata->cache_we 1 cycle; stalls on br_cmd_ready/ack/rdata_valid.
// Macro CACHE_LINE_LOADER_CRITICAL_WORD_FIRST_EN: read burst starts at the missed word, adds hit_word_valid.
module cache_line_loader #(
    parameter int COLUMN_IX_BITWIDTH = 2,
    parameter int ADDRESS_BITWIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    cache_line_loader_if.slave bus
);
    localparam int CW    = COLUMN_IX_BITWIDTH;
    localparam int AW    = ADDRESS_BITWIDTH;
    localparam int WORDS = 1 << CW;
    localparam logic [CW-1:0] LAST_BEAT = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_WB_CMD, S_WB_DATA, S_RD_CMD, S_RD_DATA, S_FILL_END, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     beat_q, beat_d;
    logic [AW-1:0]     miss_addr_q;
    logic [AW-CW-3:0]  evict_line_q;
    logic [31:0]       evict_words_q [WORDS];
    logic              cache_we_q;
    logic [AW-1:0]     cache_addr_q;
    logic [31:0]       cache_data_q;
    logic              hit_q;
    logic              capture;
    logic              rd_take;
    logic [CW-1:0]     col_base;
    logic [CW-1:0]     col;
    logic [AW-1:0]     rd_cmd_addr;
    logic              unused_bits;

`ifdef CACHE_LINE_LOADER_CRITICAL_WORD_FIRST_EN
    assign col_base    = miss_addr_q[CW+1:2];
    assign rd_cmd_addr = {miss_addr_q[AW-1:2], 2'b00};
    assign bus.hit_word_valid = hit_q;
`else
    assign col_base    = '0;
    assign rd_cmd_addr = {miss_addr_q[AW-1:CW+2], {(CW+2){1'b0}}};
`endif

    assign col         = col_base + beat_q;
    assign rd_take     = (state_q == S_RD_DATA) && bus.br_rdata_valid;
    assign unused_bits = ^{bus.evict_addr[CW+1:0], miss_addr_q[CW+1:0]};

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: if (bus.miss_req) begin
                capture = 1'b1;
                state_d = bus.evict_dirty ? S_WB_CMD : S_RD_CMD;
            end
            S_WB_CMD: if (bus.br_cmd_ready) begin
                state_d = S_WB_DATA;
                beat_d  = '0;
            end
            S_WB_DATA: if (bus.br_wdata_ack) begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) state_d = S_RD_CMD;
            end
            S_RD_CMD: if (bus.br_cmd_ready) begin
                state_d = S_RD_DATA;
                beat_d  = '0;
            end
            S_RD_DATA: if (bus.br_rdata_valid) begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) state_d = S_FILL_END;
            end
            // FILL_END is the cycle the last word is written; done follows it
            S_FILL_END: state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy         = (state_q != S_IDLE) && (state_q != S_DONE);
        bus.done         = (state_q == S_DONE);
        bus.br_cmd_valid = (state_q == S_WB_CMD) || (state_q == S_RD_CMD);
        bus.br_cmd_write = (state_q == S_WB_CMD);
        bus.br_cmd_addr  = '0;
        bus.br_wdata     = '0;
        if (state_q == S_WB_CMD) bus.br_cmd_addr = {evict_line_q, {(CW+2){1'b0}}};
        if (state_q == S_RD_CMD) bus.br_cmd_addr = rd_cmd_addr;
        if (state_q == S_WB_DATA) bus.br_wdata = evict_words_q[beat_q];
    end

    assign bus.cache_we   = cache_we_q;
    assign bus.cache_addr = cache_addr_q;
    assign bus.cache_data = cache_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            miss_addr_q  <= '0;
            evict_line_q <= '0;
            for (int k = 0; k < WORDS; k++) evict_words_q[k] <= '0;
            cache_we_q   <= 1'b0;
            cache_addr_q <= '0;
            cache_data_q <= '0;
            hit_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            cache_we_q <= rd_take;
            hit_q      <= rd_take && (col == miss_addr_q[CW+1:2]);
            if (capture) begin
                miss_addr_q  <= bus.miss_addr;
                evict_line_q <= bus.evict_addr[AW-1:CW+2];
                for (int k = 0; k < WORDS; k++) evict_words_q[k] <= bus.evict_data[32*k +: 32];
            end
            if (rd_take) begin
                cache_addr_q <= {miss_addr_q[AW-1:CW+2], col, 2'b00};
                cache_data_q <= bus.br_rdata;
            end
        end
    end
endmodule

// File: tb/tb_cache_line_loader.sv
// Randomized bench for cache_line_loader: responds as the burst RAM and checks against a line-fill model.
module tb_cache_line_loader;
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    cache_line_loader_if bus();
    cache_line_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef CACHE_LINE_LOADER_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd_cmd(input logic [31:0] ma);
        return CWF ? (ma & ~32'h3) : (ma & ~32'hF);
    endfunction

    function automatic int start_col(input logic [31:0] ma);
        return CWF ? int'((ma >> 2) & 32'h3) : 0;
    endfunction

    function automatic logic [31:0] exp_fill_addr(input logic [31:0] ma, input int k);
        return (ma & ~32'hF) | (((start_col(ma) + k) % 4) << 2);
    endfunction

    task automatic drive_idle();
        bus.miss_req       = 1'b0;
        bus.miss_addr      = '0;
        bus.evict_dirty    = 1'b0;
        bus.evict_addr     = '0;
        bus.evict_data     = '0;
        bus.br_cmd_ready   = 1'b0;
        bus.br_wdata_ack   = 1'b0;
        bus.br_rdata       = '0;
        bus.br_rdata_valid = 1'b0;
    endtask

    // ready_dly/beat_gap < 0 select random timing; abort_beats > 0 pulls reset after that many read beats
    task automatic run_miss(input logic [31:0] ma, input logic [31:0] ea, input logic dirty,
                            input logic [127:0] ed, input logic [31:0] rd_base, input int ready_dly,
                            input int beat_gap, input bit spur, input int abort_beats);
        logic [31:0] exp_cmd_addr [2];
        logic        exp_cmd_wr [2];
        int          rd_cyc [4];
        logic [31:0] rd_dat [4];
        logic [31:0] prev_addr;
        logic        prev_wr;
        int ncmd, cmd_idx, acks, beats, wi, wait_cnt, gap_cnt, cyc, last_we_cyc;
        bit seen_done, waiting, drop_chk, wr_ph, rd_ph, take;
        cmd_idx = 0; acks = 0; beats = 0; wi = 0; wait_cnt = 0; gap_cnt = 0; cyc = 0;
        last_we_cyc = -10; seen_done = 0; waiting = 0; drop_chk = 0;
        prev_addr = '0; prev_wr = 1'b0;
        if (dirty) begin
            exp_cmd_wr[0] = 1'b1; exp_cmd_addr[0] = ea & ~32'hF;
            exp_cmd_wr[1] = 1'b0; exp_cmd_addr[1] = exp_rd_cmd(ma);
            ncmd = 2;
        end else begin
            exp_cmd_wr[0] = 1'b0; exp_cmd_addr[0] = exp_rd_cmd(ma);
            exp_cmd_wr[1] = 1'b0; exp_cmd_addr[1] = '0;
            ncmd = 1;
        end
        for (int k = 0; k < 4; k++) begin
            rd_dat[k] = (rd_base != 0) ? rd_base + k : $urandom;
            rd_cyc[k] = -10;
        end

        @(negedge clk);
        chk("idle_busy", bus.busy, 1'b0);
        bus.miss_req = 1'b1; bus.miss_addr = ma; bus.evict_addr = ea;
        bus.evict_dirty = dirty; bus.evict_data = ed;

        while (!seen_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.miss_req = 1'b0;
            bus.miss_addr = $urandom; bus.evict_addr = $urandom;
            bus.evict_dirty = 1'($urandom_range(0, 1));
            bus.evict_data = {$urandom, $urandom, $urandom, $urandom};
            if (cyc == 1) begin
                chk("acc_busy", bus.busy, 1'b1);
                chk("cmd_lat", bus.br_cmd_valid, 1'b1);
            end
            if (abort_beats > 0 && beats == abort_beats) begin
                chk("pre_rst_we", bus.cache_we, 1'b1);
                rst_n = 1'b0;
                #1;
                chk("rst_flags", {bus.busy, bus.done, bus.cache_we, bus.br_cmd_valid, bus.br_cmd_write}, '0);
                chk("rst_addrs", {bus.cache_addr, bus.br_cmd_addr}, '0);
                chk("rst_data", {bus.cache_data, bus.br_wdata}, '0);
                drive_idle();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end

            if (waiting) begin
                chk("cmd_hold_v", bus.br_cmd_valid, 1'b1);
                chk("cmd_hold_a", bus.br_cmd_addr, prev_addr);
                chk("cmd_hold_w", bus.br_cmd_write, prev_wr);
            end
            if (drop_chk) chk("cmd_drop", bus.br_cmd_valid, 1'b0);
            waiting = 0; drop_chk = 0;
            if (bus.cache_we) begin
                if (wi < 4) begin
                    chk("we_addr", bus.cache_addr, exp_fill_addr(ma, wi));
                    chk("we_data", bus.cache_data, rd_dat[wi]);
                    chk("we_lat", cyc, rd_cyc[wi] + 1);
`ifdef CACHE_LINE_LOADER_CRITICAL_WORD_FIRST_EN
                    chk("hit_word", bus.hit_word_valid, ((start_col(ma) + wi) % 4) == start_col(ma));
`endif
                end else chk("we_extra", 1'b1, 1'b0);
                last_we_cyc = cyc;
                wi++;
            end
            if (bus.done) begin
                chk("done_cnt", wi, 4);
                chk("done_lat", cyc, last_we_cyc + 1);
                chk("done_busy", bus.busy, 1'b0);
                seen_done = 1;
            end

            wr_ph = dirty && cmd_idx == 1 && acks < 4;
            rd_ph = cmd_idx == ncmd && beats < 4;
            bus.br_cmd_ready = 1'b0; bus.br_wdata_ack = 1'b0;
            bus.br_rdata_valid = 1'b0; bus.br_rdata = $urandom;
            if (bus.br_cmd_valid) begin
                take = (ready_dly < 0) ? ($urandom_range(0, 1) == 1) : (wait_cnt >= ready_dly);
                if (take) begin
                    if (cmd_idx < ncmd) begin
                        chk("cmd_addr", bus.br_cmd_addr, exp_cmd_addr[cmd_idx]);
                        chk("cmd_write", bus.br_cmd_write, exp_cmd_wr[cmd_idx]);
                    end else chk("cmd_extra", 1'b1, 1'b0);
                    bus.br_cmd_ready = 1'b1;
                    cmd_idx++; wait_cnt = 0; drop_chk = 1;
                end else begin
                    wait_cnt++; waiting = 1;
                    prev_addr = bus.br_cmd_addr; prev_wr = bus.br_cmd_write;
                end
            end
            if (wr_ph) begin
                if (beat_gap >= 0 || $urandom_range(0, 1) == 1) begin
                    chk("wdata", bus.br_wdata, ed[32*acks +: 32]);
                    bus.br_wdata_ack = 1'b1;
                    acks++;
                end
            end else if (spur) bus.br_wdata_ack = ($urandom_range(0, 3) == 0);
            if (rd_ph) begin
                if (gap_cnt == 0) begin
                    bus.br_rdata_valid = 1'b1; bus.br_rdata = rd_dat[beats];
                    rd_cyc[beats] = cyc; beats++;
                    gap_cnt = (beat_gap < 0) ? int'($urandom_range(0, 2)) : beat_gap;
                end else gap_cnt--;
            end else if (spur) bus.br_rdata_valid = ($urandom_range(0, 3) == 0);
            if (spur && bus.busy && !bus.done) bus.miss_req = ($urandom_range(0, 3) == 0);
        end

        if (!seen_done) chk("timeout", 1'b0, 1'b1);
        chk("cmd_count", cmd_idx, ncmd);
        chk("ack_count", acks, dirty ? 4 : 0);
        drive_idle();
        @(negedge clk);
        chk("done_pulse", bus.done, 1'b0);
        chk("busy_after", bus.busy, 1'b0);
        chk("we_after", bus.cache_we, 1'b0);
    endtask

    task automatic idle_noise();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("noise_we", bus.cache_we, 1'b0);
            chk("noise_busy", bus.busy, 1'b0);
            bus.br_rdata_valid = 1'b1; bus.br_rdata = $urandom;
            bus.br_wdata_ack = 1'b1; bus.br_cmd_ready = 1'b1;
        end
        @(negedge clk);
        chk("noise_we", bus.cache_we, 1'b0);
        chk("noise_cmd", bus.br_cmd_valid, 1'b0);
        drive_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        chk("reset_flags", {bus.busy, bus.done, bus.cache_we, bus.br_cmd_valid, bus.br_cmd_write}, '0);
        chk("reset_addrs", {bus.cache_addr, bus.br_cmd_addr}, '0);
        chk("reset_data", {bus.cache_data, bus.br_wdata}, '0);
        rst_n = 1'b1;

        run_miss(32'h0000_1234, 32'h0000_9990, 1'b0, '0, 32'hA0, 0, 0, 1'b0, 0);
        run_miss(32'h0000_1230, 32'h0000_2230, 1'b1,
                 {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 32'hB0, 0, 0, 1'b0, 0);
        run_miss(32'h0000_5678, 32'h0000_7770, 1'b1,
                 {$urandom, $urandom, $urandom, $urandom}, 32'h0, 5, 3, 1'b0, 0);
        run_miss(32'h0000_89AC, 32'h0000_4440, 1'b0, '0, 32'h0, 1, 1, 1'b1, 0);
        idle_noise();
        run_miss(32'h0000_ABC4, 32'h0000_1110, 1'b0, '0, 32'h0, 0, 0, 1'b0, 2);
        run_miss(32'h0000_0040, 32'h0000_0000, 1'b0, '0, 32'hC0, 0, 0, 1'b0, 0);
        run_miss(32'h0000_1238, 32'h0000_3330, 1'b0, '0, 32'hE0, 0, 0, 1'b0, 0);
        for (int n = 0; n < 25; n++)
            run_miss($urandom, $urandom, 1'($urandom_range(0, 1)),
                     {$urandom, $urandom, $urandom, $urandom}, 32'h0, -1, -1, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_line_loader.md
Name: cache_line_loader

Overview:
- Miss handler that sits directly downstream of the direct-mapped 4-column cache, between the cache and the burst-capable external RAM (PSRAM) controller.
- On a miss, it writes back the victim line if it is dirty. It then fetches the 4-word line containing the missed address and streams the words into the cache write port.
- The CPU-facing logic stalls while busy is high.

Parameters:
COLUMN_IX_BITWIDTH, 2, log2 of words per line (fixed at 2: 4 words, 16-byte line)
ADDRESS_BITWIDTH, 32, byte address width on both sides

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
miss_req  input  1  request to service a miss; sampled only in IDLE
miss_addr  input  32  byte address that missed
evict_dirty  input  1  victim line holds modified data
evict_addr  input  32  byte address of victim line (low 4 bits ignored)
evict_data  input  128  victim line words; word k at bits [32k+31:32k]
busy  output  1  high from acceptance of miss_req until done
done  output  1  one-cycle pulse when line fill complete
cache_we  output  1  write strobe to cache (data + tag)
cache_addr  output  32  address of word being written into cache
cache_data  output  32  word being written into cache
br_cmd_valid  output  1  burst command valid
br_cmd_write  output  1  1 = burst write, 0 = burst read
br_cmd_addr  output  32  burst start byte address
br_cmd_ready  input  1  burst controller accepts command
br_wdata  output  32  current write-burst word
br_wdata_ack  input  1  controller consumed br_wdata
br_rdata  input  32  read-burst word
br_rdata_valid  input  1  br_rdata valid this cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, cache_we, br_cmd_valid, br_cmd_write = 0; cache_addr, cache_data, br_cmd_addr, br_wdata = 0; beat counter = 0. Reset asserted mid-burst aborts immediately. No partial-line recovery; the burst controller is reset by the same rst_n.
- IDLE:
  - miss_req=1: capture miss_addr, evict_addr, evict_data, evict_dirty into registers; busy=1 next cycle.
  - Next state is WB_CMD if evict_dirty, else RD_CMD.
- WB_CMD: br_cmd_valid=1, br_cmd_write=1, br_cmd_addr={evict_addr[31:4],4'b0}. Held stable until br_cmd_ready=1, then WB_DATA with beat=0.
- WB_DATA:
  - br_wdata = captured word[beat]. Each br_wdata_ack advances beat; br_wdata updates the next cycle.
  - After the 4th ack (beat wraps 3→0), go to RD_CMD.
- RD_CMD: br_cmd_valid=1, br_cmd_write=0, br_cmd_addr = line base of miss_addr (see optional feature). On br_cmd_ready, go to RD_DATA with beat=0.
- RD_DATA:
  - Each br_rdata_valid registers one cycle later: cache_we=1, cache_data=br_rdata, cache_addr={line[31:4], column, 2'b00}.
  - Column = beat (+ start column, mod 4).
  - After the 4th word, go to DONE.
- DONE: done=1 for exactly one cycle, coinciding with the cycle after the 4th cache_we. busy drops to 0 in the same cycle; return to IDLE. A new miss_req is accepted the following cycle.
- br_cmd_valid drops in the cycle after the handshake. Handshake completes in one cycle when br_cmd_ready is already high.
- Boundaries:
  - miss_req outside IDLE ignored.
  - br_wdata_ack outside WB_DATA ignored.
  - br_rdata_valid outside RD_DATA ignored.
  - Back-to-back br_rdata_valid on 4 consecutive cycles gives 4 consecutive cache_we.
  - Gaps between beats are allowed.
  - Column arithmetic is 2-bit wrap-around.
- Latency, clean miss, zero-wait RAM: miss_req→br_cmd_valid 1 cycle; rdata k→cache_we 1 cycle.

Optional Feature:
CACHE_LINE_LOADER_CRITICAL_WORD_FIRST_EN
- Defined:
  - Read burst starts at the missed word: br_cmd_addr={miss_addr[31:2],2'b00}.
  - Controller wraps within the line; column = miss_addr[3:2]+beat mod 4.
  - Extra output hit_word_valid (1 bit) pulses with the cache_we of the missed column, letting the CPU restart early.
- Undefined: read starts at column 0; no hit_word_valid port.

Test Plan:
- Clean miss: miss_addr=0x0000_1234, evict_dirty=0, br_cmd_ready=1, rdata 0xA0..0xA3 on consecutive cycles -> br_cmd_addr=0x0000_1230 read; cache_we×4 at 0x1230,0x1234,0x1238,0x123C with 0xA0..0xA3; done pulse 1 cycle later; busy low.
- Dirty miss: evict_addr=0x0000_2230, evict_data={0xD3,0xD2,0xD1,0xD0}, miss_addr=0x0000_1230 -> write cmd 0x2230 first, br_wdata 0xD0,0xD1,0xD2,0xD3 per ack, then read cmd 0x1230.
- Stalls: br_cmd_ready low 5 cycles, 3-cycle gaps between rdata beats -> br_cmd_addr/br_cmd_valid stable while waiting; exactly 4 cache_we, none during gaps.
- Spurious inputs: miss_req pulsed during RD_DATA, br_rdata_valid in IDLE -> no second service, no cache_we, state unaffected.
- Reset mid-burst: rst_n low after 2nd read beat -> all outputs 0 immediately; after release, fresh miss at 0x40 completes normally.
- With CACHE_LINE_LOADER_CRITICAL_WORD_FIRST_EN: miss_addr=0x1238 -> br_cmd_addr=0x1238; cache_we order 0x1238,0x123C,0x1230,0x1234; hit_word_valid on first write only.
